// File: rtl/debounce_scan_controller.sv
// debounce_scan_controller
//
// Debounces N raw button/switch lines using one shared compare/increment
// datapath. A prescaler tick starts a scan. The scan visits channels 0..N-1,
// one per clock, and updates a per-channel stability count. When a level change
// has persisted long enough, the stable output bit is updated. At the same
// time an event {index, level} is queued on a valid/ready port.
//
// Parameters
//   N          number of channels (1..256)
//   PRESCALE   clocks per scan tick (must be >= N+2)
//   EVQ_DEPTH  event FIFO depth (power of 2, >= 2)
//
// Ports
//   clock        system clock, all logic on posedge
//   reset        synchronous, active-high
//   in[N]        raw inputs
//   delay[8]     scans a changed level must persist before acceptance
//   out[N]       debounced stable levels
//   ev_valid     event FIFO not empty
//   ev_ready     consumer accepts head event when ev_valid && ev_ready
//   ev_index     channel of head event
//   ev_level     new stable level of head event
//   ev_overflow  sticky: an event was dropped because the FIFO was full
//
// Configuration macro
//   DEBOUNCE_SYNC2_EN  when defined, each input passes through a 2-flop
//                      synchroniser. Otherwise a single register stage is
//                      used, which is suitable only for inputs that are
//                      already synchronous to clock.

module debounce_scan_controller #(
  parameter int N         = 4,
  parameter int PRESCALE  = 1000,
  parameter int EVQ_DEPTH = 4,
  localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  in,
  input  logic [7:0]    delay,
  output logic [N-1:0]  out,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [IW-1:0] ev_index,
  output logic          ev_level,
  output logic          ev_overflow
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int AW = (EVQ_DEPTH > 1) ? $clog2(EVQ_DEPTH) : 1;

  // ---------------------------------------------------------------------------
  // Input sampling stage
  // ---------------------------------------------------------------------------
  logic [N-1:0] samp_q;

`ifdef DEBOUNCE_SYNC2_EN
  logic [N-1:0] meta_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      samp_q <= '0;
    end else begin
      meta_q <= in;
      samp_q <= meta_q;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      samp_q <= '0;
    end else begin
      samp_q <= in;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Prescaler: counts 0..PRESCALE-1; tick is high for one clock at the wrap
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre_q;
  logic          tick;

  assign tick = (pre_q == PW'(PRESCALE - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM and shared per-channel datapath
  // ---------------------------------------------------------------------------
  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q;
  logic [IW-1:0] ch_q;
  logic [7:0]    dly_q;
  logic [N-1:0]  out_q;
  logic [7:0]    cnt_q [N];

  // The selected channel's sample, stable level and count feed the one
  // compare/increment path.
  logic       cur_s;
  logic       cur_o;
  logic [7:0] cur_cnt;
  logic       push;

  always_comb begin
    cur_s   = samp_q[ch_q];
    cur_o   = out_q[ch_q];
    cur_cnt = cnt_q[ch_q];
    // The comparison uses >= rather than ==. If delay is lowered between
    // scans, a count already past the new threshold is still accepted on
    // the next scan. It does not run up to saturation and get stuck there.
    push    = (state_q == SCAN) && (cur_s != cur_o) && (cur_cnt >= dly_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      dly_q   <= '0;
      out_q   <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            dly_q   <= delay;
            ch_q    <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (cur_s == cur_o) begin
            cnt_q[ch_q] <= '0;
          end else if (push) begin
            out_q[ch_q] <= cur_s;
            cnt_q[ch_q] <= '0;
          end else if (cur_cnt != 8'hFF) begin
            cnt_q[ch_q] <= cur_cnt + 8'd1;
          end

          if (ch_q == IW'(N - 1)) begin
            state_q <= IDLE;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out = out_q;

  // ---------------------------------------------------------------------------
  // Event FIFO
  // Entries sit in a RAM array with a registered read into a head register.
  // The head register is what ev_* present, so the FIFO is first-word-
  // fall-through. A push into an empty FIFO lands in the RAM first and reaches
  // the head one clock later. Total occupancy is the RAM count plus the head
  // register, and it is capped at EVQ_DEPTH.
  // ---------------------------------------------------------------------------
  logic [IW:0]   mem [EVQ_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   mem_count_q;
  logic          head_valid_q;
  logic [IW-1:0] head_index_q;
  logic          head_level_q;
  logic          overflow_q;

  logic [AW:0] occupancy;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic        load;

  always_comb begin
    occupancy = mem_count_q + {{AW{1'b0}}, head_valid_q};
    full      = (occupancy == (AW+1)'(EVQ_DEPTH));
    pop       = head_valid_q && ev_ready;
    // When the FIFO is full, a pop in the same cycle frees the slot the push needs.
    push_ok   = push && (!full || pop);
    load      = (!head_valid_q || pop) && (mem_count_q != '0);
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= {ch_q, cur_s};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_count_q  <= '0;
      head_valid_q <= 1'b0;
      head_index_q <= '0;
      head_level_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (load) begin
        rd_ptr_q                     <= rd_ptr_q + 1'b1;
        {head_index_q, head_level_q} <= mem[rd_ptr_q];
        head_valid_q                 <= 1'b1;
      end else if (pop) begin
        head_valid_q <= 1'b0;
      end

      case ({push_ok, load})
        2'b10:   mem_count_q <= mem_count_q + 1'b1;
        2'b01:   mem_count_q <= mem_count_q - 1'b1;
        default: mem_count_q <= mem_count_q;
      endcase

      if (push && !push_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign ev_valid    = head_valid_q;
  assign ev_index    = head_index_q;
  assign ev_level    = head_level_q;
  assign ev_overflow = overflow_q;

endmodule

// File: tb/tb_debounce_scan_controller.sv
// Testbench for debounce_scan_controller with N=4, PRESCALE=8, EVQ_DEPTH=4.
// Time is counted in clocks since the last reset edge (cyc). Scan j processes
// channel c on edge 8j+9+c, and the FSM goes back to IDLE on edge 8j+12.
// Inputs are driven, and outputs sampled, 1 time unit after a rising edge.

module tb_debounce_scan_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic [7:0] delay;
  logic [3:0] dout;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_index;
  logic       ev_level;
  logic       ev_overflow;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int pops        = 0;

  debounce_scan_controller #(
    .N         (4),
    .PRESCALE  (8),
    .EVQ_DEPTH (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in          (din),
    .delay       (delay),
    .out         (dout),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_index    (ev_index),
    .ev_level    (ev_level),
    .ev_overflow (ev_overflow)
  );

  always #5 clock = ~clock;

  // Clocks since reset was last sampled high, and accepted events since then.
  always @(posedge clock) begin
    if (reset) begin
      cyc  <= 0;
      pops <= 0;
    end else begin
      cyc <= cyc + 1;
      if (ev_valid && ev_ready) pops <= pops + 1;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  task automatic do_reset(input logic [7:0] d, input logic rdy);
    reset    = 1'b1;
    din      = 4'b0000;
    delay    = d;
    ev_ready = rdy;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Advance to 1 time unit after edge k, counted from the reset edge.
  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    din = 4'b1111;
    delay = 8'd3;
    ev_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (dout !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_out: got %b want 0000", dout);
    end
    vectors++;
    if ({ev_valid, ev_index, ev_level, ev_overflow} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ev: got %b want 00000", {ev_valid, ev_index, ev_level, ev_overflow});
    end
  endtask

  // in[2] rises and is held; with delay=3 it is accepted on scan 3, on edge 35.
  task automatic test_steady_accept;
    do_reset(8'd3, 1'b1);
    din = 4'b0100;
    goto(34);
    vectors++;
    if (dout !== 4'b0000) begin
      miscompares++;
      $display("FAIL t1_before: got %b want 0000", dout);
    end
    goto(35);
    vectors++;
    if ({dout, ev_valid} !== 5'b01000) begin
      miscompares++;
      $display("FAIL t1_accept: got %b want 01000", {dout, ev_valid});
    end
    goto(36);
    vectors++;
    if ({ev_valid, ev_index, ev_level} !== 4'b1101) begin
      miscompares++;
      $display("FAIL t1_event: got %b want 1101", {ev_valid, ev_index, ev_level});
    end
    goto(80);
    vectors++;
    if ({dout, ev_valid} !== 5'b01000 || pops !== 1) begin
      miscompares++;
      $display("FAIL t1_after: got out/valid %b pops %0d want 01000 pops 1", {dout, ev_valid}, pops);
    end
  endtask

  // in[1] is high for 2 scans, then low; it must restart from a zero count.
  task automatic test_glitch;
    do_reset(8'd3, 1'b1);
    din = 4'b0010;
    goto(20);
    din = 4'b0000;
    goto(28);
    vectors++;
    if (dout !== 4'b0000 || pops !== 0) begin
      miscompares++;
      $display("FAIL t2_glitch: got out %b pops %0d want 0000 pops 0", dout, pops);
    end
    din = 4'b0010;
    goto(57);
    vectors++;
    if (dout !== 4'b0000) begin
      miscompares++;
      $display("FAIL t2_cnt_cleared: got %b want 0000", dout);
    end
    goto(58);
    vectors++;
    if (dout !== 4'b0010) begin
      miscompares++;
      $display("FAIL t2_late_accept: got %b want 0010", dout);
    end
    goto(60);
    vectors++;
    if (pops !== 1) begin
      miscompares++;
      $display("FAIL t2_events: got %0d want 1", pops);
    end
  endtask

  // delay=0 accepts on the first scan. Changing delay mid-scan waits for the next scan.
  task automatic test_zero_delay;
    do_reset(8'd0, 1'b0);
    din = 4'b1000;
    goto(9);
    delay = 8'd3;
    goto(11);
    vectors++;
    if (dout !== 4'b0000) begin
      miscompares++;
      $display("FAIL t3_before: got %b want 0000", dout);
    end
    goto(12);
    vectors++;
    if (dout !== 4'b1000) begin
      miscompares++;
      $display("FAIL t3_accept: got %b want 1000", dout);
    end
    goto(13);
    vectors++;
    if ({ev_valid, ev_index, ev_level} !== 4'b1111) begin
      miscompares++;
      $display("FAIL t3_event: got %b want 1111", {ev_valid, ev_index, ev_level});
    end
    din = 4'b0000;
    goto(43);
    vectors++;
    if (dout !== 4'b1000) begin
      miscompares++;
      $display("FAIL t3_new_delay_hold: got %b want 1000", dout);
    end
    goto(44);
    vectors++;
    if (dout !== 4'b0000) begin
      miscompares++;
      $display("FAIL t3_new_delay_accept: got %b want 0000", dout);
    end
  endtask

  // All channels change with ev_ready=0. A fifth change overflows, then the FIFO drains.
  task automatic test_overflow;
    logic [3:0] exp_head [4];
    exp_head[0] = 4'b1001;
    exp_head[1] = 4'b1011;
    exp_head[2] = 4'b1101;
    exp_head[3] = 4'b1111;
    do_reset(8'd3, 1'b0);
    din = 4'b1111;
    goto(37);
    vectors++;
    if ({dout, ev_valid, ev_index, ev_level, ev_overflow} !== 9'b1111_1001_0) begin
      miscompares++;
      $display("FAIL t4_full: got %b want 111110010", {dout, ev_valid, ev_index, ev_level, ev_overflow});
    end
    din = 4'b1110;
    goto(64);
    vectors++;
    if ({dout, ev_overflow} !== 5'b11110) begin
      miscompares++;
      $display("FAIL t4_pre_drop: got %b want 11110", {dout, ev_overflow});
    end
    goto(65);
    vectors++;
    if ({dout, ev_overflow} !== 5'b11101) begin
      miscompares++;
      $display("FAIL t4_drop: got %b want 11101", {dout, ev_overflow});
    end
    goto(66);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      goto(66 + i);
      vectors++;
      if ({ev_valid, ev_index, ev_level} !== exp_head[i]) begin
        miscompares++;
        $display("FAIL t4_drain%0d: got %b want %b", i, {ev_valid, ev_index, ev_level}, exp_head[i]);
      end
    end
    goto(70);
    vectors++;
    if ({ev_valid, ev_overflow} !== 2'b01) begin
      miscompares++;
      $display("FAIL t4_empty: got %b want 01", {ev_valid, ev_overflow});
    end
  endtask

  // On a full FIFO, a pop in the same cycle as a push lets both succeed.
  task automatic test_back_to_back;
    logic [3:0] exp_head [5];
    exp_head[0] = 4'b1011;
    exp_head[1] = 4'b1101;
    exp_head[2] = 4'b1111;
    exp_head[3] = 4'b1000;
    exp_head[4] = 4'b0000;
    do_reset(8'd3, 1'b0);
    din = 4'b1111;
    goto(37);
    din = 4'b1110;
    goto(64);
    ev_ready = 1'b1;
    goto(65);
    vectors++;
    if ({dout, ev_overflow} !== 5'b11100) begin
      miscompares++;
      $display("FAIL t5_push_pop: got %b want 11100", {dout, ev_overflow});
    end
    for (int i = 0; i < 5; i++) begin
      goto(65 + i);
      vectors++;
      if ({ev_valid, ev_valid ? {ev_index, ev_level} : 3'b000} !== exp_head[i]) begin
        miscompares++;
        $display("FAIL t5_drain%0d: got %b want %b", i, {ev_valid, ev_index, ev_level}, exp_head[i]);
      end
    end
    vectors++;
    if (ev_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL t5_no_overflow: got %b want 0", ev_overflow);
    end
  endtask

  // Reset mid-scan with out=1010 and 2 events queued.
  task automatic test_reset_mid_scan;
    do_reset(8'd0, 1'b0);
    din = 4'b1010;
    goto(17);
    vectors++;
    if ({dout, ev_valid, ev_index, ev_level} !== 8'b1010_1011) begin
      miscompares++;
      $display("FAIL t6_setup: got %b want 10101011", {dout, ev_valid, ev_index, ev_level});
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    vectors++;
    if ({dout, ev_valid, ev_overflow} !== 6'b0) begin
      miscompares++;
      $display("FAIL t6_cleared: got %b want 000000", {dout, ev_valid, ev_overflow});
    end
    goto(9);
    vectors++;
    if (dout !== 4'b0000) begin
      miscompares++;
      $display("FAIL t6_restart_early: got %b want 0000", dout);
    end
    goto(10);
    vectors++;
    if (dout !== 4'b0010) begin
      miscompares++;
      $display("FAIL t6_restart_accept: got %b want 0010", dout);
    end
    goto(11);
    vectors++;
    if ({ev_valid, ev_index, ev_level} !== 4'b1011) begin
      miscompares++;
      $display("FAIL t6_restart_event: got %b want 1011", {ev_valid, ev_index, ev_level});
    end
  endtask

  initial begin
    reset    = 1'b1;
    din      = 4'b0000;
    delay    = 8'd3;
    ev_ready = 1'b0;
    test_reset();
    test_steady_accept();
    test_glitch();
    test_zero_delay();
    test_overflow();
    test_back_to_back();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
